wht2d_stream_engine: RTL and testbench

//  Streaming 4x4 2-D Walsh-Hadamard transform engine with ready/valid flow control.
//  - Per-block forward or inverse mode; optional hard thresholding of transform coefficients.
//  - Input: one 4-sample row per beat. Row 1-D WHT is written into a ping-pong transpose buffer.
//  - Output: column 1-D WHT, one 4-coefficient column per beat.
//  - Successor to the fixed-width wht_2d pipeline: parametrised width, backpressure, mode, threshold.

---
 rtl/wht2d_stream_engine_if.sv | 29 ++
 rtl/wht2d_stream_engine.sv | 161 ++++++++++++++++
 tb/tb_wht2d_stream_engine.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wht2d_stream_engine_if.sv
// wht2d_stream_engine_if: row-in / column-out stream bundle for wht2d_stream_engine.
// slave is the engine side, master is the producer/consumer side.
interface wht2d_stream_engine_if #(
  parameter int WIDTH_IN = 9,
  parameter int TH_W     = 12
);
  localparam int WIDTH_OUT = WIDTH_IN + 4;

  logic [4*WIDTH_IN-1:0]  in_row;
  logic                   in_inv;
  logic                   in_valid;
  logic                   in_ready;
  logic [TH_W-1:0]        hard_th;
  logic [4*WIDTH_OUT-1:0] out_col;
  logic                   out_inv;
  logic                   out_last;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output in_row, in_inv, in_valid, hard_th, out_ready,
    input  in_ready, out_col, out_inv, out_last, out_valid
  );

  modport slave (
    input  in_row, in_inv, in_valid, hard_th, out_ready,
    output in_ready, out_col, out_inv, out_last, out_valid
  );
endinterface

// File: rtl/wht2d_stream_engine.sv
// wht2d_stream_engine: streaming 4x4 2-D Walsh-Hadamard transform.
// One row per input beat goes through the row butterfly into a ping-pong
// transpose buffer; each full bank is read one column per beat through the
// column butterfly into the output register. Each block carries its own
// forward/inverse mode (inverse divides by 16 with round half-up).
// Optional macro WHT_HARD_THRESH_EN: forward coefficients with |c| < hard_th
// are zeroed (DC exempt). Without it hard_th is ignored.
module wht2d_stream_engine #(
  parameter int WIDTH_IN = 9,
  parameter int TH_W     = 12
) (
  input logic                  clk,
  input logic                  rst,
  wht2d_stream_engine_if.slave bus
);
  localparam int WIDTH_OUT = WIDTH_IN + 4;
  localparam int ROW_W     = WIDTH_IN + 2;
  localparam int SUM_W     = WIDTH_OUT + 1;

  typedef logic signed [ROW_W-1:0]     row_t;
  typedef logic signed [WIDTH_OUT-1:0] coef_t;
  typedef logic signed [SUM_W-1:0]     sum_t;

  // Transpose buffer and per-bank block attributes
  row_t       mem [2][4][4];   // [bank][row][col]
  logic [1:0] full;
  logic [1:0] bank_inv;
`ifdef WHT_HARD_THRESH_EN
  localparam int CMP_W = ((WIDTH_OUT > TH_W) ? WIDTH_OUT : TH_W) + 1;
  logic [TH_W-1:0]  bank_th [2];
  logic [CMP_W-1:0] mag [4];
`else
  logic unused_hard_th;
  assign unused_hard_th = ^bus.hard_th;
`endif

  // wr_bank: filling; ld_bank: being read into the output register;
  // rd_bank: the bank whose last column is released on consumption.
  logic       wr_bank, ld_bank, rd_bank;
  logic [1:0] row_cnt, col_cnt;

  logic                   out_valid_q, out_inv_q, out_last_q;
  logic [4*WIDTH_OUT-1:0] out_col_q;

  logic accept, load, blk_done;

  assign accept   = bus.in_valid && !full[wr_bank];
  assign load     = full[ld_bank] && (!out_valid_q || bus.out_ready);
  assign blk_done = out_valid_q && bus.out_ready && out_last_q;

  assign bus.in_ready  = !full[wr_bank];
  assign bus.out_valid = out_valid_q;
  assign bus.out_col   = out_col_q;
  assign bus.out_inv   = out_inv_q;
  assign bus.out_last  = out_last_q;

  // Row butterfly on the incoming samples, sign-extended to the row-stage width
  row_t s_ext   [4];
  row_t row_wht [4];
  always_comb begin
    for (int i = 0; i < 4; i++)
      s_ext[i] = ROW_W'(signed'(bus.in_row[i*WIDTH_IN +: WIDTH_IN]));
    row_wht[0] = s_ext[0] + s_ext[1] + s_ext[2] + s_ext[3];
    row_wht[1] = s_ext[0] - s_ext[1] + s_ext[2] - s_ext[3];
    row_wht[2] = s_ext[0] + s_ext[1] - s_ext[2] - s_ext[3];
    row_wht[3] = s_ext[0] - s_ext[1] - s_ext[2] + s_ext[3];
  end

  // Column butterfly on the selected column, then inverse scaling or threshold
  coef_t c_ext   [4];
  coef_t col_wht [4];
  sum_t  rnd     [4];
  coef_t col_res [4];
  always_comb begin
    // NOTE: every variable of this block gets a value before any branch,
    // so no path can leave one holding its old value (no latch).
    for (int r = 0; r < 4; r++) begin
      c_ext[r] = WIDTH_OUT'(mem[ld_bank][r][col_cnt]);
`ifdef WHT_HARD_THRESH_EN
      mag[r] = '0;
`endif
    end
    col_wht[0] = c_ext[0] + c_ext[1] + c_ext[2] + c_ext[3];
    col_wht[1] = c_ext[0] - c_ext[1] + c_ext[2] - c_ext[3];
    col_wht[2] = c_ext[0] + c_ext[1] - c_ext[2] - c_ext[3];
    col_wht[3] = c_ext[0] - c_ext[1] - c_ext[2] + c_ext[3];
    for (int r = 0; r < 4; r++) begin
      rnd[r]     = sum_t'(col_wht[r]) + sum_t'(8);
      col_res[r] = col_wht[r];
      if (bank_inv[ld_bank]) begin
        col_res[r] = coef_t'(rnd[r] >>> 4);
      end
`ifdef WHT_HARD_THRESH_EN
      else if (!((r == 0) && (col_cnt == 2'd0))) begin
        mag[r] = col_wht[r][WIDTH_OUT-1] ? CMP_W'(-sum_t'(col_wht[r]))
                                         : CMP_W'(sum_t'(col_wht[r]));
        if (mag[r] < CMP_W'(bank_th[ld_bank]))
          col_res[r] = '0;
      end
`endif
    end
  end

  // Buffer write and per-block attribute capture on row acceptance
  // NOTE: the buffer and block attributes carry no reset; the full flags
  // alone decide whether their contents are meaningful.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < 4; c++)
        mem[wr_bank][row_cnt][c] <= row_wht[c];
      if (row_cnt == 2'd0) begin
        bank_inv[wr_bank] <= bus.in_inv;
`ifdef WHT_HARD_THRESH_EN
        bank_th[wr_bank]  <= bus.hard_th;
`endif
      end
    end
  end

  // Bank bookkeeping, column sequencing and the output register
  // NOTE: all state here uses <= so every update sees pre-edge values;
  // a bank fill and a bank release in the same cycle both take effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      full        <= 2'b00;
      wr_bank     <= 1'b0;
      ld_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      row_cnt     <= 2'd0;
      col_cnt     <= 2'd0;
      out_valid_q <= 1'b0;
      out_inv_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_col_q   <= '0;
    end else begin
      if (blk_done) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if (accept) begin
        row_cnt <= row_cnt + 2'd1;
        if (row_cnt == 2'd3) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      if (load) begin
        out_valid_q <= 1'b1;
        out_inv_q   <= bank_inv[ld_bank];
        out_last_q  <= (col_cnt == 2'd3);
        for (int r = 0; r < 4; r++)
          out_col_q[r*WIDTH_OUT +: WIDTH_OUT] <= col_res[r];
        col_cnt <= col_cnt + 2'd1;
        if (col_cnt == 2'd3)
          ld_bank <= ~ld_bank;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wht2d_stream_engine.sv
// Scoreboard bench for wht2d_stream_engine: stimulus pushes hand-computed
// column beats into a queue; a monitor pops and compares on each consumed beat.
module tb_wht2d_stream_engine;
  localparam int WI = 9;
  localparam int TW = 12;
  localparam int WO = WI + 4;

  typedef struct packed {
    logic [4*WO-1:0] col;
    logic            inv;
    logic            last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   beat_no  = 0;
  beat_t exp_q [$];

  wht2d_stream_engine_if #(.WIDTH_IN(WI), .TH_W(TW)) bus ();

  wht2d_stream_engine #(.WIDTH_IN(WI), .TH_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [4*WI-1:0] mk_row(input int a, input int b, input int c, input int d);
    logic [4*WI-1:0] r;
    r[0*WI +: WI] = a[WI-1:0];
    r[1*WI +: WI] = b[WI-1:0];
    r[2*WI +: WI] = c[WI-1:0];
    r[3*WI +: WI] = d[WI-1:0];
    return r;
  endfunction

  function automatic logic [4*WO-1:0] mk_col(input int a, input int b, input int c, input int d);
    logic [4*WO-1:0] r;
    r[0*WO +: WO] = a[WO-1:0];
    r[1*WO +: WO] = b[WO-1:0];
    r[2*WO +: WO] = c[WO-1:0];
    r[3*WO +: WO] = d[WO-1:0];
    return r;
  endfunction

  task automatic push_block(input logic [4*WO-1:0] c0, input logic [4*WO-1:0] c1,
                            input logic [4*WO-1:0] c2, input logic [4*WO-1:0] c3,
                            input logic inv);
    exp_q.push_back('{col: c0, inv: inv, last: 1'b0});
    exp_q.push_back('{col: c1, inv: inv, last: 1'b0});
    exp_q.push_back('{col: c2, inv: inv, last: 1'b0});
    exp_q.push_back('{col: c3, inv: inv, last: 1'b1});
  endtask

  // Present one row and hold it until the engine accepts it (bounded)
  task automatic send_row(input logic [4*WI-1:0] row, input logic inv, input logic [TW-1:0] th);
    logic acc;
    int   waited = 0;
    bus.in_row   = row;
    bus.in_inv   = inv;
    bus.hard_th  = th;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      waited++;
      if (waited > 300) begin
        n_checks++;
        $display("FAIL row_accept_timeout: waited %0d cycles, required acceptance", waited);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [4*WI-1:0] r0, input logic [4*WI-1:0] r1,
                            input logic [4*WI-1:0] r2, input logic [4*WI-1:0] r3,
                            input logic inv, input logic [TW-1:0] th);
    send_row(r0, inv, th);
    send_row(r1, inv, th);
    send_row(r2, inv, th);
    send_row(r3, inv, th);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed beat is compared against the head of the queue
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got col %0h with no beat expected", bus.out_col);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("beat%0d_col", beat_no),  64'(bus.out_col),  64'(e.col));
          check($sformatf("beat%0d_inv", beat_no),  64'(bus.out_inv),  64'(e.inv));
          check($sformatf("beat%0d_last", beat_no), 64'(bus.out_last), 64'(e.last));
        end
        beat_no++;
      end
    end
  end

  initial begin
    logic [4*WI-1:0] z_row;
    logic [4*WO-1:0] z_col;
    z_row = '0;
    z_col = '0;
    bus.in_row    = '0;
    bus.in_inv    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.hard_th   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_col",   64'(bus.out_col),   64'd0);
    check("rst_out_inv",   64'(bus.out_inv),   64'd0);
    check("rst_out_last",  64'(bus.out_last),  64'd0);

    bus.out_ready = 1'b1;

    // Forward DC
    push_block(mk_col(16,0,0,0), z_col, z_col, z_col, 1'b0);
    send_block(mk_row(1,1,1,1), mk_row(1,1,1,1), mk_row(1,1,1,1), mk_row(1,1,1,1), 1'b0, 12'd0);
    wait_drain();

    // Inverse: every element 1
    push_block(mk_col(1,1,1,1), mk_col(1,1,1,1), mk_col(1,1,1,1), mk_col(1,1,1,1), 1'b1);
    send_block(mk_row(16,0,0,0), z_row, z_row, z_row, 1'b1, 12'd0);
    wait_drain();

    // Threshold: th=5 kills all but DC when enabled, th=4 keeps everything
`ifdef WHT_HARD_THRESH_EN
    push_block(mk_col(4,0,0,0), z_col, z_col, z_col, 1'b0);
`else
    push_block(mk_col(4,4,4,4), mk_col(4,4,4,4), mk_col(4,4,4,4), mk_col(4,4,4,4), 1'b0);
`endif
    send_block(mk_row(4,0,0,0), z_row, z_row, z_row, 1'b0, 12'd5);
    push_block(mk_col(4,4,4,4), mk_col(4,4,4,4), mk_col(4,4,4,4), mk_col(4,4,4,4), 1'b0);
    send_block(mk_row(4,0,0,0), z_row, z_row, z_row, 1'b0, 12'd4);
    // Negative coefficients: magnitude 3 below threshold 4
`ifdef WHT_HARD_THRESH_EN
    push_block(mk_col(-3,0,0,0), z_col, z_col, z_col, 1'b0);
`else
    push_block(mk_col(-3,-3,-3,-3), mk_col(-3,-3,-3,-3), mk_col(-3,-3,-3,-3), mk_col(-3,-3,-3,-3), 1'b0);
`endif
    send_block(mk_row(-3,0,0,0), z_row, z_row, z_row, 1'b0, 12'd4);
    wait_drain();

    // Row-stage signs: row0 {1,2,3,4} -> {10,-2,-4,0}, replicated down each column
    push_block(mk_col(10,10,10,10), mk_col(-2,-2,-2,-2), mk_col(-4,-4,-4,-4), z_col, 1'b0);
    send_block(mk_row(1,2,3,4), z_row, z_row, z_row, 1'b0, 12'd0);
    // Column-stage signs: column {1,2,3,4} in every column
    push_block(mk_col(10,-2,-4,0), mk_col(10,-2,-4,0), mk_col(10,-2,-4,0), mk_col(10,-2,-4,0), 1'b0);
    send_block(mk_row(1,0,0,0), mk_row(2,0,0,0), mk_row(3,0,0,0), mk_row(4,0,0,0), 1'b0, 12'd0);
    // Inverse rounding: 23 -> 1, 25 -> 2; then -9 -> -1
    push_block(mk_col(1,1,1,1), mk_col(2,2,2,2), mk_col(1,1,1,1), mk_col(2,2,2,2), 1'b1);
    send_block(mk_row(24,-1,0,0), z_row, z_row, z_row, 1'b1, 12'd0);
    push_block(mk_col(-1,-1,-1,-1), mk_col(-1,-1,-1,-1), mk_col(-1,-1,-1,-1), mk_col(-1,-1,-1,-1), 1'b1);
    send_block(mk_row(-9,0,0,0), z_row, z_row, z_row, 1'b1, 12'd0);
    wait_drain();

    // Backpressure: fwd / inv / fwd blocks with the output stalled
    bus.out_ready = 1'b0;
    push_block(mk_col(16,0,0,0), z_col, z_col, z_col, 1'b0);
    send_block(mk_row(1,1,1,1), mk_row(1,1,1,1), mk_row(1,1,1,1), mk_row(1,1,1,1), 1'b0, 12'd0);
    push_block(mk_col(1,1,1,1), mk_col(1,1,1,1), mk_col(1,1,1,1), mk_col(1,1,1,1), 1'b1);
    send_block(mk_row(16,0,0,0), z_row, z_row, z_row, 1'b1, 12'd0);
    check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    push_block(mk_col(4,4,4,4), mk_col(4,4,4,4), mk_col(4,4,4,4), mk_col(4,4,4,4), 1'b0);
    fork
      send_block(mk_row(4,0,0,0), z_row, z_row, z_row, 1'b0, 12'd4);
      begin
        repeat (6) @(posedge clk);
        #1;
        check("bp_in_ready_still_low", 64'(bus.in_ready), 64'd0);
        check("bp_out_valid_held", 64'(bus.out_valid), 64'd1);
        check("bp_out_col_held", 64'(bus.out_col), 64'(mk_col(16,0,0,0)));
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    // Extremes: all samples -256
    push_block(mk_col(-4096,0,0,0), z_col, z_col, z_col, 1'b0);
    send_block(mk_row(-256,-256,-256,-256), mk_row(-256,-256,-256,-256),
               mk_row(-256,-256,-256,-256), mk_row(-256,-256,-256,-256), 1'b0, 12'd0);
    wait_drain();

    // Reset mid-block with a stored block stalled at the output
    bus.out_ready = 1'b0;
    send_block(mk_row(7,7,7,7), mk_row(7,7,7,7), mk_row(7,7,7,7), mk_row(7,7,7,7), 1'b0, 12'd0);
    send_row(mk_row(5,5,5,5), 1'b0, 12'd0);
    send_row(mk_row(5,5,5,5), 1'b0, 12'd0);
    check("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("mid_rst_out_last",  64'(bus.out_last),  64'd0);
    bus.out_ready = 1'b1;
    push_block(mk_col(16,0,0,0), z_col, z_col, z_col, 1'b0);
    send_block(mk_row(1,1,1,1), mk_row(1,1,1,1), mk_row(1,1,1,1), mk_row(1,1,1,1), 1'b0, 12'd0);
    wait_drain();
    repeat (10) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
